seg7_display_engine: RTL and testbench
======================================

SEG7_DISPLAY_ENGINE -- requirements
Module: seg7_display_engine

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of 7-segment digits driven (1..8).
REQ-002 SHALL have parameter DATA_W, default 16, binary input width (4..32).
REQ-003 SHALL have parameter TICK_DIV, default 50_000_000, clk_50M cycles per page toggle.
REQ-004 SHALL have port clk_50M, input, 1, sole clock; one clock; reset is synchronous and active-high.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port load, input, 1, start request, sampled high on a rising edge.
REQ-007 SHALL have port data, input, DATA_W, value to display.
REQ-008 SHALL have port mode, input, 2, display mode: 0 decimal, 1 hex, 2 text, 3 reserved (treated as hex).
REQ-009 SHALL have port busy, output, 1, high from the edge after load acceptance until done.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when new segments first appear.
REQ-011 SHALL have port overflow, output, 1, decimal value needs more than DIGITS digits.
REQ-012 SHALL have port page, output, 1, 0 = low window shown, 1 = high window shown.
REQ-013 SHALL have port segments, output, 7*DIGITS, active-low, digit k at [7k+6:7k] = {g,f,e,d,c,b,a}, digit 0 rightmost.

Function
REQ-014 SHALL run FSM IDLE -> CONVERT -> LATCH -> IDLE, with data and mode captured on the accepting edge.
REQ-015 SHALL accept load only in IDLE; load in CONVERT or LATCH is ignored, not queued.
REQ-016 SHALL, in decimal mode, convert by iterative double-dabble, one bit per cycle, DATA_W cycles in CONVERT.
REQ-017 SHALL, in hex and text modes, skip CONVERT (IDLE -> LATCH).
REQ-018 SHALL update segments and pulse done at edge N+DATA_W+2 (decimal) or N+2 (hex/text), where load is sampled at edge N.
REQ-019 SHALL hold segments stable between updates; busy is high exactly while the FSM is in CONVERT or LATCH.
REQ-020 SHALL size the BCD register as BCD_DIGITS = (DATA_W*3)/10+1 digits.
REQ-021 SHALL set overflow when any BCD digit at index >= DIGITS is nonzero; overflow is cleared in hex/text modes.
REQ-022 SHALL, with overflow high, toggle page every TICK_DIV cycles; page 1 shows BCD digits [BCD_DIGITS-1 : BCD_DIGITS-DIGITS], page 0 shows [DIGITS-1:0].
REQ-023 SHALL, with overflow low, hold page at 0 and reset the page counter.
REQ-024 SHALL, in hex mode, show the low DIGITS nibbles of data as glyphs 0-9 and A,b,C,d,E,F.
REQ-025 SHALL, in text mode, map each nibble code 0..8 to blank,I,d,l,E,o,n,r,u; codes 9..15 SHALL be blank.
REQ-026 SHALL show blank as 7'h7F.

Reset
REQ-027 SHALL, on rst, force FSM IDLE, busy=0, done=0, overflow=0, page=0, page counter=0, and all segments blank; this applies mid-conversion too, aborting the conversion.
REQ-028 SHALL give rst priority over a simultaneous load.

Configuration
REQ-029 SHALL, with macro SEG7_LEADING_ZERO_BLANK_EN defined, blank zero digits left of the most significant nonzero digit of the shown window in decimal mode, always keeping digit 0 lit; page 1 is never blanked.
REQ-030 SHALL, without SEG7_LEADING_ZERO_BLANK_EN, show all digits including leading zeros.

Structure
REQ-031 SHALL place the mode encoding, FSM state type, glyph constants, and the BCD_DIGITS calculation in package seg7_pkg.
REQ-032 SHALL use one combinational sub-module, seg7_glyph (4-bit code plus mode -> 7-bit active-low segments), instantiated DIGITS times.

Verification
REQ-033 SHALL cover: DIGITS=4, DATA_W=16, decimal load 1234 -> digits 1,2,3,4, done at N+18, overflow=0.
REQ-034 SHALL cover: decimal 65535 with TICK_DIV=10 -> overflow=1, page 0 shows "5535", page 1 shows "6553", page toggling every 10 cycles.
REQ-035 SHALL cover: hex 0xBEEF -> b,E,E,F with done at N+2; then text 0x1234 -> I,d,l,E.
REQ-036 SHALL cover: load of 99 at cycle N+5 during busy -> ignored, and the first result 1234 is displayed unchanged.
REQ-037 SHALL cover: rst asserted at cycle N+8 mid-conversion -> the next edge gives all segments 7'h7F, busy=0, and no done pulse.
REQ-038 SHALL cover: with SEG7_LEADING_ZERO_BLANK_EN, decimal 42 -> blank,blank,4,2; decimal 0 -> blank,blank,blank,0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display engine.
// Glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

   typedef enum logic [1:0] {
      MODE_DEC  = 2'd0,
      MODE_HEX  = 2'd1,
      MODE_TEXT = 2'd2,
      MODE_RSVD = 2'd3
   } mode_t;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_CONVERT = 2'd1;
   localparam state_t ST_LATCH   = 2'd2;

   localparam logic [6:0] GLYPH_BLANK = 7'h7F;

   localparam logic [6:0] HEX_GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // blank, I, d, l, E, o, n, r, u; remaining codes blank
   localparam logic [6:0] TEXT_GLYPH [16] = '{
      7'h7F, 7'h4F, 7'h21, 7'h47, 7'h06, 7'h23, 7'h2B, 7'h2F,
      7'h63, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
   };

   function automatic int unsigned bcd_digits(input int unsigned width);
      return (width * 3) / 10 + 1;
   endfunction

endpackage

// File: rtl/seg7_display_engine_glyph.sv
// Combinational glyph decoder: 4-bit code plus display mode to active-low segments.
module seg7_glyph
   import seg7_pkg::*;
(
   input  logic [3:0] code,
   input  logic [1:0] mode,
   output logic [6:0] segments
);

   always_comb begin
      if (mode == MODE_TEXT) segments = TEXT_GLYPH[code];
      else                   segments = HEX_GLYPH[code];
   end

endmodule

// File: rtl/seg7_display_engine.sv
// Multi-digit 7-segment engine: decimal (double-dabble), hex and text display with paging.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zeros on the decimal low page.
module seg7_display_engine
   import seg7_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int DATA_W   = 16,
   parameter int TICK_DIV = 50_000_000
) (
   input  logic                  clk_50M,
   input  logic                  rst,
   input  logic                  load,
   input  logic [DATA_W-1:0]     data,
   input  logic [1:0]            mode,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic                  page,
   output logic [7*DIGITS-1:0]   segments
);

   localparam int BCD_DIGITS  = bcd_digits(DATA_W);
   localparam int WORD_DIGITS = (BCD_DIGITS > DIGITS) ? BCD_DIGITS : DIGITS;
   localparam int WORD_W      = 4 * WORD_DIGITS;
   localparam int P1_BASE     = (BCD_DIGITS > DIGITS) ? BCD_DIGITS - DIGITS : 0;
   localparam int CNT_W       = $clog2(DATA_W + 1);
   localparam int TICK_W      = $clog2(TICK_DIV + 1);

   state_t                  state;
   logic                    lat_phase;
   logic [CNT_W-1:0]        bit_cnt;
   logic [DATA_W-1:0]       data_r;
   logic [DATA_W-1:0]       bin;
   logic [1:0]              mode_r;
   logic [4*BCD_DIGITS-1:0] bcd;
   logic [4*BCD_DIGITS-1:0] bcd_adj;
   logic                    ovf_next;
   logic [1:0]              disp_mode;
   logic [WORD_W-1:0]       disp_word;
   logic                    shown;
   logic [TICK_W-1:0]       tick_cnt;
   logic [3:0]              codes [DIGITS];
   logic [1:0]              gmode [DIGITS];
   logic [6:0]              glyph_seg [DIGITS];

   assign busy = (state != ST_IDLE);

   always_comb begin
      bcd_adj = bcd;
      for (int unsigned i = 0; i < BCD_DIGITS; i++)
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
   end

   always_comb begin
      ovf_next = 1'b0;
      for (int unsigned i = DIGITS; i < BCD_DIGITS; i++)
         ovf_next = ovf_next | (|bcd[4*i +: 4]);
   end

   // LATCH spends two cycles so results land exactly two edges after leaving IDLE/CONVERT
   always_ff @(posedge clk_50M) begin
      if (rst) begin
         state     <= ST_IDLE;
         lat_phase <= 1'b0;
         bit_cnt   <= '0;
         data_r    <= '0;
         bin       <= '0;
         mode_r    <= '0;
         bcd       <= '0;
         disp_mode <= '0;
         disp_word <= '0;
         shown     <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
         page      <= 1'b0;
         tick_cnt  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (load) begin
                  data_r    <= data;
                  bin       <= data;
                  mode_r    <= mode;
                  bcd       <= '0;
                  bit_cnt   <= '0;
                  lat_phase <= 1'b0;
                  state     <= (mode == MODE_DEC) ? ST_CONVERT : ST_LATCH;
               end
            end
            ST_CONVERT: begin
               bcd     <= (bcd_adj << 1) | {{(4*BCD_DIGITS-1){1'b0}}, bin[DATA_W-1]};
               bin     <= bin << 1;
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == CNT_W'(DATA_W - 1)) state <= ST_LATCH;
            end
            ST_LATCH: begin
               if (!lat_phase) begin
                  lat_phase <= 1'b1;
               end else begin
                  lat_phase <= 1'b0;
                  state     <= ST_IDLE;
                  disp_mode <= mode_r;
                  disp_word <= (mode_r == MODE_DEC) ? WORD_W'(bcd) : WORD_W'(data_r);
                  overflow  <= (mode_r == MODE_DEC) && ovf_next;
                  shown     <= 1'b1;
                  done      <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if ((state == ST_LATCH && lat_phase) || !overflow) begin
            page     <= 1'b0;
            tick_cnt <= '0;
         end else if (tick_cnt == TICK_W'(TICK_DIV - 1)) begin
            page     <= ~page;
            tick_cnt <= '0;
         end else begin
            tick_cnt <= tick_cnt + 1'b1;
         end
      end
   end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   logic lead;
`endif

   // Blanked digits reuse the text table, whose code 0 is blank
   always_comb begin
      for (int unsigned k = 0; k < DIGITS; k++) begin
         if (disp_mode == MODE_DEC && page) codes[k] = disp_word[4*(k+P1_BASE) +: 4];
         else                               codes[k] = disp_word[4*k +: 4];
         gmode[k] = disp_mode;
      end
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      lead = 1'b1;
      if (disp_mode == MODE_DEC && !page) begin
         for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
            if (lead && codes[k] == 4'd0) gmode[k] = MODE_TEXT;
            else                          lead = 1'b0;
         end
      end
`endif
   end

   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      seg7_glyph u_glyph (
         .code     (codes[k]),
         .mode     (gmode[k]),
         .segments (glyph_seg[k])
      );
      assign segments[7*k +: 7] = shown ? glyph_seg[k] : GLYPH_BLANK;
   end

endmodule

// File: tb/tb_seg7_display_engine.sv
// Scoreboard bench for seg7_display_engine: expected results queued at load, checked on done.
`timescale 1ns/1ps
module tb_seg7_display_engine;

   localparam int DIGITS   = 4;
   localparam int DATA_W   = 16;
   localparam int TICK_DIV = 10;

   logic          clk_50M = 1'b0;
   logic          rst;
   logic          load;
   logic [15:0]   data;
   logic [1:0]    mode;
   logic          busy;
   logic          done;
   logic          overflow;
   logic          page;
   logic [27:0]   segments;

   always #10 clk_50M = ~clk_50M;

   seg7_display_engine #(
      .DIGITS   (DIGITS),
      .DATA_W   (DATA_W),
      .TICK_DIV (TICK_DIV)
   ) dut (
      .clk_50M  (clk_50M),
      .rst      (rst),
      .load     (load),
      .data     (data),
      .mode     (mode),
      .busy     (busy),
      .done     (done),
      .overflow (overflow),
      .page     (page),
      .segments (segments)
   );

   localparam logic [6:0] G_0 = 7'h40, G_1 = 7'h79, G_2 = 7'h24, G_3 = 7'h30;
   localparam logic [6:0] G_4 = 7'h19, G_5 = 7'h12, G_6 = 7'h02, G_A = 7'h08;
   localparam logic [6:0] G_B = 7'h03, G_E = 7'h06, G_F = 7'h0E, G_BL = 7'h7F;
   localparam logic [6:0] T_I = 7'h4F, T_D = 7'h21, T_L = 7'h47, T_E = 7'h06, T_O = 7'h23;

   typedef struct {
      logic [27:0] seg;
      logic        ovf;
      int unsigned due;
   } exp_t;

   exp_t        sb[$];
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;
   int unsigned cyc         = 0;
   int unsigned last_done   = 0;

   always @(posedge clk_50M) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(negedge clk_50M) begin : monitor
      exp_t e;
      if (!rst && done) begin
         last_done = cyc;
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
         end else begin
            e = sb.pop_front();
            check("segments", 32'(segments), 32'(e.seg));
            check("overflow", 32'(overflow), 32'(e.ovf));
            check("done_cycle", cyc, e.due);
            check("busy_at_done", 32'(busy), 32'd0);
         end
      end
   end

   task automatic push_exp(input logic [27:0] es, input logic eo, input int unsigned due);
      exp_t e;
      e.seg = es;
      e.ovf = eo;
      e.due = due;
      sb.push_back(e);
   endtask

   task automatic issue(input logic [1:0] m, input logic [15:0] d,
                        input logic [27:0] es, input logic eo);
      @(negedge clk_50M);
      load = 1'b1;
      mode = m;
      data = d;
      push_exp(es, eo, cyc + 1 + ((m == 2'd0) ? DATA_W + 2 : 2));
      @(negedge clk_50M);
      load = 1'b0;
   endtask

   task automatic wait_idle();
      int unsigned n = 0;
      while ((busy || sb.size() != 0) && n < 100) begin
         @(negedge clk_50M);
         n++;
      end
      if (n >= 100) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout: got busy=%0d pending=%0d, expected idle within 100 cycles", busy, sb.size());
         sb.delete();
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got no completion, expected finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int unsigned n0;
      int unsigned d0;
      logic [27:0] dec_42;
      logic [27:0] dec_0;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
      dec_42 = {G_BL, G_BL, G_4, G_2};
      dec_0  = {G_BL, G_BL, G_BL, G_0};
`else
      dec_42 = {G_0, G_0, G_4, G_2};
      dec_0  = {G_0, G_0, G_0, G_0};
`endif

      rst  = 1'b1;
      load = 1'b0;
      data = '0;
      mode = '0;
      repeat (3) @(negedge clk_50M);
      check("reset_segments", 32'(segments), 32'({4{G_BL}}));
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_overflow", 32'(overflow), 32'd0);
      check("reset_page", 32'(page), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk_50M);

      // decimal 1234 with a second load at N+5 that must be ignored
      load = 1'b1;
      mode = 2'd0;
      data = 16'd1234;
      n0   = cyc + 1;
      push_exp({G_1, G_2, G_3, G_4}, 1'b0, n0 + 18);
      @(negedge clk_50M);
      load = 1'b0;
      while (cyc < n0 + 4) @(negedge clk_50M);
      check("busy_mid_convert", 32'(busy), 32'd1);
      load = 1'b1;
      data = 16'd99;
      @(negedge clk_50M);
      load = 1'b0;
      wait_idle();
      repeat (5) @(negedge clk_50M);
      check("held_after_ignored_load", 32'(segments), 32'({G_1, G_2, G_3, G_4}));
      check("page_no_overflow", 32'(page), 32'd0);

      // 65535: overflow and paging
      issue(2'd0, 16'd65535, {G_5, G_5, G_3, G_5}, 1'b1);
      wait_idle();
      d0 = last_done;
      while (cyc < d0 + 9) @(negedge clk_50M);
      check("page_before_tick", 32'(page), 32'd0);
      @(negedge clk_50M);
      check("page_after_tick", 32'(page), 32'd1);
      check("page1_segments", 32'(segments), 32'({G_6, G_5, G_5, G_3}));
      check("overflow_held", 32'(overflow), 32'd1);
      while (cyc < d0 + 20) @(negedge clk_50M);
      check("page_second_tick", 32'(page), 32'd0);
      check("page0_segments", 32'(segments), 32'({G_5, G_5, G_3, G_5}));

      // hex clears overflow and paging
      issue(2'd1, 16'hBEEF, {G_B, G_E, G_E, G_F}, 1'b0);
      wait_idle();
      repeat (2) @(negedge clk_50M);
      check("page_after_hex", 32'(page), 32'd0);

      issue(2'd2, 16'h1234, {T_I, T_D, T_L, T_E}, 1'b0);
      wait_idle();
      issue(2'd2, 16'h9F05, {G_BL, G_BL, G_BL, T_O}, 1'b0);
      wait_idle();
      issue(2'd3, 16'h00A5, {G_0, G_0, G_A, G_5}, 1'b0);
      wait_idle();
      issue(2'd0, 16'd42, dec_42, 1'b0);
      wait_idle();
      issue(2'd0, 16'd0, dec_0, 1'b0);
      wait_idle();

      // reset mid-conversion aborts with no done pulse
      @(negedge clk_50M);
      load = 1'b1;
      mode = 2'd0;
      data = 16'd1234;
      n0   = cyc + 1;
      @(negedge clk_50M);
      load = 1'b0;
      while (cyc < n0 + 7) @(negedge clk_50M);
      rst = 1'b1;
      @(negedge clk_50M);
      check("abort_segments", 32'(segments), 32'({4{G_BL}}));
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_overflow", 32'(overflow), 32'd0);
      rst = 1'b0;
      repeat (30) @(negedge clk_50M);
      check("abort_still_idle", 32'(busy), 32'd0);
      check("abort_still_blank", 32'(segments), 32'({4{G_BL}}));

      wait_idle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
